cla_adder: RTL and testbench
============================

CLA_ADDER -- requirements
Module: cla_adder

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; SHALL be a multiple of 4 in range 4..32.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 a  input  WIDTH  addend A, unsigned.
REQ-005 b  input  WIDTH  addend B, unsigned.
REQ-006 cin  input  1  carry-in.
REQ-007 in_valid  input  1  high = a/b/cin qualify as a new operation this cycle.
REQ-008 s  output  WIDTH  registered sum, a+b+cin modulo 2^WIDTH.
REQ-009 cout  output  1  registered carry-out, bit WIDTH of a+b+cin.
REQ-010 pg  output  1  registered group propagate: AND of all bit propagates (a[i]^b[i]).
REQ-011 gg  output  1  registered group generate: carry-out with cin forced to 0.
REQ-012 out_valid  output  1  high for exactly the cycle(s) in which s/cout/pg/gg hold a result qualified by in_valid.

Function
REQ-013 Per bit: p[i]=a[i]^b[i], g[i]=a[i]&b[i]; s[i]=p[i]^c[i]; c[0]=cin.
REQ-014 Carries SHALL be computed by lookahead in 4-bit blocks: c[i+1]=g[i]|p[i]&c[i], expanded within each block so no bit carry depends on a ripple chain longer than the block.
REQ-015 Each 4-bit block SHALL produce block P (AND of its p) and block G; carries between blocks SHALL come from a second-level lookahead unit over block P/G (not block-to-block ripple).
REQ-016 Datapath from a/b/cin to the output registers SHALL be purely combinational; no input registers.
REQ-017 Latency: result for inputs sampled at rising edge N SHALL appear on s/cout/pg/gg/out_valid after edge N (valid during cycle N+1).
REQ-018 When in_valid=1 at an edge: s, cout, pg, gg SHALL load the new result and out_valid SHALL become 1.
REQ-019 When in_valid=0 at an edge: s, cout, pg, gg SHALL hold their previous values and out_valid SHALL become 0.
REQ-020 Back-to-back in_valid=1 SHALL produce one result per cycle with no bubbles; no backpressure exists.
REQ-021 Overflow: sum wraps modulo 2^WIDTH; cout SHALL be 1 exactly when a+b+cin >= 2^WIDTH.
REQ-022 Boundary: a=b=all-ones, cin=1 SHALL give s=all-ones, cout=1, pg=0, gg=1.
REQ-023 Boundary: a^b=all-ones, cin=1 SHALL give s=0, cout=1, pg=1, gg=0 (full-length propagate).
REQ-024 X-free: with known inputs and after reset, no output SHALL be X or Z.

Reset
REQ-025 rst_n low SHALL immediately (without waiting for clk) force s=0, cout=0, pg=0, gg=0, out_valid=0.
REQ-026 While rst_n is low, in_valid SHALL be ignored and outputs SHALL remain at reset values.
REQ-027 Reset asserted mid-stream SHALL discard any result not yet presented; first result after release SHALL come from the first in_valid=1 edge after rst_n goes high.
REQ-028 rst_n release is synchronized externally; the block SHALL need no internal reset synchronizer.

Verification
REQ-029 WIDTH=4, a=0000, b=0000, cin=1, in_valid=1 -> next cycle s=0001, cout=0, pg=0, gg=0, out_valid=1.
REQ-030 WIDTH=4, a=0001, b=0011, cin=1, in_valid=1 -> next cycle s=0101, cout=0, pg=0, gg=0, out_valid=1.
REQ-031 WIDTH=4, a=1111, b=1111, cin=1 -> s=1111, cout=1, pg=0, gg=1; then a=1010, b=0101, cin=1 -> s=0000, cout=1, pg=1, gg=0.
REQ-032 Valid hold: result loaded, then in_valid=0 for 3 cycles with changing a/b -> s/cout unchanged, out_valid=0.
REQ-033 Async reset: assert rst_n low between clock edges while out_valid=1 -> all outputs 0 before next edge; release, in_valid=1 with a=0111, b=0001, cin=0 -> s=1000, cout=0.
REQ-034 WIDTH=16 exhaustive-random: 10,000 random a/b/cin back-to-back -> every cycle {cout,s} equals a+b+cin of previous cycle, pg/gg match reference equations.

Source files
------------

// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder: 4-bit lookahead blocks joined by
// a second-level lookahead unit over block propagate/generate.
module cla_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             pg,
  output logic             gg,
  output logic             out_valid
);

  localparam int unsigned NB = WIDTH / 4;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  logic [NB-1:0]    bp;
  logic [NB-1:0]    bg;
  logic [NB:0]      bc;
  logic             grp_gen;

  // Block P/G and second-level lookahead; every block carry is a flat
  // sum-of-products over block P/G and cin, never a ripple through bc.
  always_comb begin
    logic carry;
    logic pr;
    p       = a ^ b;
    g       = a & b;
    bp      = '0;
    bg      = '0;
    bc      = '0;
    grp_gen = 1'b0;
    carry   = 1'b0;
    pr      = 1'b1;
    for (int unsigned j = 0; j < NB; j++) begin
      bp[j] = p[4*j] & p[4*j+1] & p[4*j+2] & p[4*j+3];
      bg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    bc[0] = cin;
    for (int unsigned j = 0; j < NB; j++) begin
      carry = 1'b0;
      pr    = 1'b1;
      for (int unsigned k = 0; k <= j; k++) begin
        carry = carry | (pr & bg[j-k]);
        pr    = pr & bp[j-k];
      end
      bc[j+1] = carry | (pr & cin);
      if (j == NB - 1) begin
        grp_gen = carry;
      end
    end
  end

  // In-block carries expanded from the block carry-in.
  always_comb begin
    c = '0;
    for (int unsigned j = 0; j < NB; j++) begin
      c[4*j]   = bc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & bc[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & bc[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & bc[j]);
    end
    c[WIDTH] = bc[NB];
    sum      = p ^ c[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      cout      <= 1'b0;
      pg        <= 1'b0;
      gg        <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      s         <= sum;
      cout      <= c[WIDTH];
      pg        <= &p;
      gg        <= grp_gen;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_adder.sv
// Scoreboarded bench for cla_adder: directed WIDTH=4 steps and a random
// back-to-back WIDTH=16 run.
module tb_cla_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        pg;
    logic        gg;
    logic        ov;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0]  a4 = '0, b4 = '0, s4;
  logic        cin4 = 1'b0, iv4 = 1'b0, cout4, pg4, gg4, ov4;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        cin16 = 1'b0, iv16 = 1'b0, cout16, pg16, gg16, ov16;

  int unsigned total = 0;
  int unsigned bad = 0;

  res_t  q4[$];
  res_t  q16[$];
  string t4[$];
  res_t  last4 = '0;
  res_t  last16 = '0;

  always #5 clk = ~clk;

  cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
    .s(s4), .cout(cout4), .pg(pg4), .gg(gg4), .out_valid(ov4)
  );

  cla_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16), .in_valid(iv16),
    .s(s16), .cout(cout16), .pg(pg16), .gg(gg16), .out_valid(ov16)
  );

  function automatic res_t model(input int unsigned w, input logic [15:0] x,
                                 input logic [15:0] y, input logic ci);
    res_t        r;
    logic [16:0] full;
    logic [16:0] nc;
    logic [15:0] mask;
    mask   = 16'hffff >> (16 - w);
    full   = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    nc     = {1'b0, x} + {1'b0, y};
    r.s    = full[15:0] & mask;
    r.cout = full[w];
    r.gg   = nc[w];
    r.pg   = (((x ^ y) & mask) == mask);
    r.ov   = 1'b1;
    return r;
  endfunction

  function automatic res_t obs4();
    return {12'h000, s4, cout4, pg4, gg4, ov4};
  endfunction

  function automatic res_t obs16();
    return {s16, cout16, pg16, gg16, ov16};
  endfunction

  task automatic cmp(input string tag, input res_t obs, input res_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop4();
    res_t  e;
    string t;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      t = t4.pop_front();
      cmp(t, obs4(), e);
    end
  endtask

  task automatic pop16();
    if (q16.size() > 0) cmp("rand16", obs16(), q16.pop_front());
  endtask

  task automatic drive4(input string tag, input logic [3:0] x, input logic [3:0] y,
                        input logic ci, input logic v);
    @(negedge clk);
    pop4();
    a4 = x; b4 = y; cin4 = ci; iv4 = v;
    if (v) last4 = model(4, {12'h000, x}, {12'h000, y}, ci);
    else   last4.ov = 1'b0;
    q4.push_back(last4);
    t4.push_back(tag);
  endtask

  task automatic drive16(input logic [15:0] x, input logic [15:0] y, input logic ci);
    @(negedge clk);
    pop16();
    a16 = x; b16 = y; cin16 = ci; iv16 = 1'b1;
    last16 = model(16, x, y, ci);
    q16.push_back(last16);
  endtask

  initial begin
    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    cmp("reset4", obs4(), '0);
    cmp("reset16", obs16(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    drive4("cin_only", 4'b0000, 4'b0000, 1'b1, 1'b1);
    drive4("small",    4'b0001, 4'b0011, 1'b1, 1'b1);
    drive4("all_ones", 4'b1111, 4'b1111, 1'b1, 1'b1);
    drive4("full_prop",4'b1010, 4'b0101, 1'b1, 1'b1);
    drive4("no_carry", 4'b0110, 4'b0001, 1'b0, 1'b1);
    drive4("wrap",     4'b1000, 4'b1000, 1'b0, 1'b1);
    drive4("hold1",    4'b1111, 4'b0001, 1'b1, 1'b0);
    drive4("hold2",    4'b0101, 4'b0101, 1'b0, 1'b0);
    drive4("hold3",    4'b1110, 4'b0011, 1'b1, 1'b0);
    drive4("reload",   4'b0011, 4'b1100, 1'b0, 1'b1);
    @(negedge clk);
    pop4();

    // Asynchronous reset while a result is presented
    drive4("pre_rst",  4'b1001, 4'b0110, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    cmp("pre_rst_valid", obs4(), last4);
    q4.delete();
    t4.delete();
    rst_n = 1'b0;
    #1;
    cmp("async_rst", obs4(), '0);
    a4 = 4'b0111; b4 = 4'b0111; cin4 = 1'b1; iv4 = 1'b1;
    @(posedge clk);
    #1;
    cmp("rst_ignores_valid", obs4(), '0);
    @(negedge clk);
    iv4 = 1'b0;
    rst_n = 1'b1;
    last4 = '0;
    drive4("post_rst", 4'b0111, 4'b0001, 1'b0, 1'b1);
    drive4("post_rst_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    pop4();
    iv4 = 1'b0;

    // WIDTH=16 boundaries, then random back-to-back operations
    drive16(16'hffff, 16'hffff, 1'b1);
    drive16(16'haaaa, 16'h5555, 1'b1);
    drive16(16'haaaa, 16'h5555, 1'b0);
    drive16(16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 10000; i++) begin
      drive16(16'($urandom), 16'($urandom), 1'($urandom));
    end
    @(negedge clk);
    pop16();
    iv16 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
